// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the TIMER opcode responder.
//   TIM_OPCODE  major opcode decoded upstream by the control unit
//   TIM_WIDTH   default width of prescaler / auto-reload / counter
//   tim_op_e    funct3 sub-operations
//   tim_dec_t   one-hot decoded command, qualified by cmd_valid
package timer_pkg;

    localparam logic [6:0] TIM_OPCODE = 7'b0100101;
    localparam int         TIM_WIDTH  = 16;

    typedef enum logic [2:0] {
        OP_ENABLE  = 3'b000,
        OP_PSC_I   = 3'b001,
        OP_ARR_I   = 3'b010,
        OP_PSC_REG = 3'b100,
        OP_ARR_REG = 3'b101,
        OP_DISABLE = 3'b111
    } tim_op_e;

    typedef struct packed {
        logic ena;
        logic dis;
        logic psc_wr;
        logic arr_wr;
        logic illegal;
    } tim_dec_t;

    // Decode is gated by valid so an idle bus can carry any funct3 value.
    function automatic tim_dec_t tim_decode(logic valid, logic [2:0] funct3);
        tim_dec_t d;
        d = '0;
        if (valid) begin
            case (funct3)
                OP_ENABLE:             d.ena     = 1'b1;
                OP_PSC_I, OP_PSC_REG:  d.psc_wr  = 1'b1;
                OP_ARR_I, OP_ARR_REG:  d.arr_wr  = 1'b1;
                OP_DISABLE:            d.dis     = 1'b1;
                default:               d.illegal = 1'b1;  // 011, 110
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/timer_unit_if.sv
// timer_unit_if: command/status bundle between the execute-stage control
// unit (master) and the timer (slave).
//   cmd_valid/cmd_funct3/cmd_imm/cmd_rs1  one-cycle TIMER command
//   flag_clr                              clears the sticky update flag
//   tim_en/tim_cnt/tim_upd/tim_flag       timer status
//   cmd_illegal                           pulse for unsupported funct3
interface timer_unit_if
    import timer_pkg::*;
#(
    parameter int WIDTH = TIM_WIDTH
);
    logic             cmd_valid;
    logic [2:0]       cmd_funct3;
    logic [WIDTH-1:0] cmd_imm;
    logic [WIDTH-1:0] cmd_rs1;
    logic             flag_clr;

    logic             tim_en;
    logic [WIDTH-1:0] tim_cnt;
    logic             tim_upd;
    logic             tim_flag;
    logic             cmd_illegal;

    modport master (
        output cmd_valid, cmd_funct3, cmd_imm, cmd_rs1, flag_clr,
        input  tim_en, tim_cnt, tim_upd, tim_flag, cmd_illegal
    );

    modport slave (
        input  cmd_valid, cmd_funct3, cmd_imm, cmd_rs1, flag_clr,
        output tim_en, tim_cnt, tim_upd, tim_flag, cmd_illegal
    );
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the core clock by (psc+1).
//   clk, reset_n  core clock, async active-low reset
//   en            count enable; psc_cnt holds its value while low
//   psc           active prescaler compare value
//   tick          combinational, high in the cycle psc_cnt==psc while enabled
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int WIDTH = TIM_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] psc,
    output logic             tick
);
    logic [WIDTH-1:0] psc_cnt;
    logic             hit;

    assign hit  = (psc_cnt == psc);
    assign tick = en & hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_cnt <= '0;
        end else if (en) begin
            psc_cnt <= hit ? '0 : psc_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/timer_unit.sv
// timer_unit: responder for the TIMER opcode in the execute stage.
//   clk, reset_n  core clock, async active-low reset
//   bus           timer_unit_if.slave: command in, status out
// Holds command decode, shadow/active prescaler and auto-reload registers,
// the main counter, and the update pulse / sticky flag.
module timer_unit
    import timer_pkg::*;
#(
    parameter int WIDTH = TIM_WIDTH
) (
    input  logic        clk,
    input  logic        reset_n,
    timer_unit_if.slave bus
);
    tim_dec_t         dec;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] psc_act, psc_shd;
    logic [WIDTH-1:0] arr_act, arr_shd;
    logic [WIDTH-1:0] cnt;
    logic             en_q;
    logic             run;
    logic             tick;
    logic             upd_evt;
    logic             upd_q, flag_q, ill_q;

    assign dec     = tim_decode(bus.cmd_valid, bus.cmd_funct3);
    assign operand = bus.cmd_funct3[2] ? bus.cmd_rs1 : bus.cmd_imm;

    // A DISABLE in execute suppresses this cycle's count, so a tick that
    // would have landed together with it never happens.
    assign run = en_q & ~dec.dis;

    timer_prescaler #(.WIDTH(WIDTH)) u_psc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run),
        .psc     (psc_act),
        .tick    (tick)
    );

    assign upd_evt = tick & (cnt == arr_act);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= 1'b0;
        end else if (dec.ena) begin
            en_q <= 1'b1;
        end else if (dec.dis) begin
            en_q <= 1'b0;
        end
    end

    // Shadows always take the write. Actives follow the write immediately
    // only while stopped; while running they reload at the update event,
    // which uses the shadow value from before any coincident write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_shd <= '0;
            psc_act <= '0;
            arr_shd <= '1;
            arr_act <= '1;
        end else begin
            if (dec.psc_wr) psc_shd <= operand;
            if (dec.arr_wr) arr_shd <= operand;

            if (upd_evt) begin
                psc_act <= psc_shd;
                arr_act <= arr_shd;
            end else if (!en_q) begin
                if (dec.psc_wr) psc_act <= operand;
                if (dec.arr_wr) arr_act <= operand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= upd_evt ? '0 : cnt + 1'b1;
        end
    end

    // Set has priority over clear on the sticky flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_q  <= 1'b0;
            flag_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            upd_q <= upd_evt;
            ill_q <= dec.illegal;
            if (upd_evt) begin
                flag_q <= 1'b1;
            end else if (bus.flag_clr) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign bus.tim_en      = en_q;
    assign bus.tim_cnt     = cnt;
    assign bus.tim_upd     = upd_q;
    assign bus.tim_flag    = flag_q;
    assign bus.cmd_illegal = ill_q;
endmodule

// File: doc/timer_unit.md
# timer_unit

Memory-free timer peripheral that executes the custom TIMER opcode (7'b0100101) issued by the control unit. It is the responder end of the decoder's timer command path: it takes the decoded funct3 sub-operation and its operand, and maintains prescaler, auto-reload and counter registers. It raises an update event on counter wrap. It sits beside the ALU in the execute stage and exposes count and flag status to the core.

## Interface
- WIDTH, 16: width of prescaler, auto-reload and counter registers.
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  one-cycle strobe: a TIMER instruction is in execute.
- cmd_funct3  in  3  sub-operation: 000 ENABLE, 001 PSC_I, 010 ARR_I, 100 PSC_REG, 101 ARR_REG, 111 DISABLE.
- cmd_imm  in  WIDTH  immediate operand, used by funct3[2]=0.
- cmd_rs1  in  WIDTH  register operand, used by funct3[2]=1.
- flag_clr  in  1  clears tim_flag.
- tim_en  out  1  timer running.
- tim_cnt  out  WIDTH  current counter value.
- tim_upd  out  1  one-cycle update-event pulse.
- tim_flag  out  1  sticky update flag.
- cmd_illegal  out  1  one-cycle pulse for funct3 011 or 110.

## Operation
- All registers are reset asynchronously when reset_n=0. Reset values: tim_en=0, psc_act=psc_shd=0, arr_act=arr_shd=all ones, psc_cnt=0, tim_cnt=0, tim_upd=0, tim_flag=0, cmd_illegal=0.
- Operand selection: funct3[2] ? cmd_rs1 : cmd_imm.
- ENABLE sets tim_en. DISABLE clears it. Counters freeze when disabled and are not cleared. ENABLE while already enabled has no effect.
- PSC_*/ARR_* write the shadow register (psc_shd/arr_shd).
  - If tim_en=0 at the write, the active register is also loaded on the same edge.
  - If tim_en=1, active registers load from the shadows only at the next update event.
- Counting (tim_en=1):
  - psc_cnt increments each cycle.
  - When psc_cnt==psc_act, psc_cnt←0 and a tick occurs.
  - On a tick, tim_cnt increments. When tim_cnt==arr_act it instead wraps to 0 and an update event occurs.
- Update event: tim_upd=1 for one cycle, tim_flag←1, and psc_act←psc_shd, arr_act←arr_shd.
- Boundaries:
  - PSC=0 gives a tick every cycle.
  - ARR=0 holds tim_cnt at 0 and produces an update every tick.
  - All arithmetic is unsigned modulo 2^WIDTH.
  - A shadow write in the same cycle as an update event: the active register takes the pre-write shadow value; the new value applies at the following update.
  - flag_clr coincident with an update event: set wins, tim_flag stays 1.
  - DISABLE coincident with a pending tick: the disable wins and no tick occurs.
  - Illegal funct3 changes no state and pulses cmd_illegal.
  - cmd_valid=0 ignores all cmd_* inputs.
- Reset mid-count returns every register to its reset value immediately.

## Timing
- Commands are single-cycle with no backpressure. The effect is visible in the cycle after the cmd_valid cycle.
- Example: ENABLE at cycle N with PSC=0, ARR=2.
  - tim_en=1 in N+1.
  - tim_cnt reads 1 in N+2 and 2 in N+3.
  - tim_cnt reads 0 with tim_upd=1 in N+4.
- Update period = (psc_act+1)·(arr_act+1) cycles.
- tim_upd, tim_flag and cmd_illegal are registered outputs, with no combinational input-to-output path.
- tim_flag rises in the same cycle tim_upd is high and falls the cycle after flag_clr.

## Structure
- Package timer_pkg holds:
  - TIM_OPCODE = 7'b0100101.
  - enum tim_op_e for the six funct3 codes.
  - Parameter default TIM_WIDTH=16.
- Sub-module timer_prescaler (WIDTH) contains psc_cnt and the compare logic. Ports: clk, reset_n, en, psc, tick. It emits tick.
- Top level holds command decode, the shadow/active registers, the counter and the flag logic.

## Test plan
- Reset, then PSC_I 0, ARR_I 2, ENABLE -> tim_upd pulses every 3 cycles; tim_cnt sequence 1,2,0; tim_flag set at first wrap.
- Enabled with PSC=1, ARR=3, then ARR_REG rs1=5 mid-period -> the current period still ends at 3; the next period counts to 5 (wraps after 6 ticks = 12 cycles).
- Update event coincident with flag_clr -> tim_flag stays 1; flag_clr alone in the next cycle -> tim_flag 0 the cycle after.
- DISABLE at tim_cnt=2, wait 10 cycles, ENABLE -> tim_cnt holds 2 throughout, then resumes at 3.
- cmd_funct3=011 with cmd_imm=7 -> cmd_illegal one-cycle pulse; PSC, ARR, tim_en and tim_cnt unchanged.
- reset_n asserted mid-period, asynchronous to clk -> all outputs return to reset values before the next edge; ARR reads all-ones behaviour after re-enable (no update for 2^16 ticks).
